// File: rtl/banco_reg_param_if.sv
// Register-file access bus: decode reads/reservations, write-back writes.
// Parameters must match the banco_reg_param instance attached to it.
interface banco_reg_param_if #(
  parameter int LARGURA     = 64,
  parameter int NUM_REGS    = 32,
  parameter int NUM_LEITURA = 2
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic                           rf_we;
  logic [AW-1:0]                  endereco_regd;
  logic [LARGURA-1:0]             dado_escrita;
  logic [NUM_LEITURA*AW-1:0]      endereco_leitura;
  logic [NUM_LEITURA*LARGURA-1:0] valor_leitura;
  logic                           reserva_en;
  logic [AW-1:0]                  endereco_reserva;
  logic [NUM_LEITURA-1:0]         ocupado;
  logic [CW-1:0]                  num_pendentes;

  modport master (
    output rf_we, endereco_regd, dado_escrita,
    output endereco_leitura, reserva_en,
    output endereco_reserva,
    input  valor_leitura, ocupado, num_pendentes
  );

  modport slave (
    input  rf_we, endereco_regd, dado_escrita,
    input  endereco_leitura, reserva_en,
    input  endereco_reserva,
    output valor_leitura, ocupado, num_pendentes
  );
endinterface

// File: rtl/banco_reg_param.sv
// Parametrised register file with write bypass and
// a per-register pending-write scoreboard for RAW hazards.
module banco_reg_param #(
  parameter int LARGURA      = 64,
  parameter int NUM_REGS     = 32,
  parameter int NUM_LEITURA  = 2,
  parameter int BYPASS       = 1,
  parameter int RESET_INDICE = 1
) (
  input logic clk,
  input logic rst_n,
  banco_reg_param_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);
  localparam logic [AW:0] LIM = (AW+1)'(NUM_REGS);

  // r0 and out-of-range addresses are never real targets
  function automatic logic valido(
    input logic [AW-1:0] a
  );
    return (a != '0) && ({1'b0, a} < LIM);
  endfunction

  logic [LARGURA-1:0]  mem [NUM_REGS];
  logic [NUM_REGS-1:0] pend;
  logic [CW-1:0]       cnt;

  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic          wr_ok;
  logic          rs_ok;
  logic          mesmo;
  logic          inc;
  logic          dec;

  assign wa = bus.endereco_regd;
  assign ra = bus.endereco_reserva;

  // Held reset hides any in-flight write from the read path
  assign wr_ok = rst_n && bus.rf_we && valido(wa);
  assign rs_ok = rst_n && bus.reserva_en && valido(ra);
  assign mesmo = rs_ok && (ra == wa);

  // Reservation set wins over the write clear on one register
  assign inc = rs_ok && !pend[ra];
  assign dec = wr_ok && pend[wa] && !mesmo;

  // Storage, pending bits and incremental pending count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= (RESET_INDICE != 0) ? LARGURA'(i) : '0;
      end
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) begin
        mem[wa]  <= bus.dado_escrita;
        pend[wa] <= 1'b0;
      end
      if (rs_ok) begin
        pend[ra] <= 1'b1;
      end
      cnt <= cnt + CW'(inc) - CW'(dec);
    end
  end

  logic [NUM_LEITURA*LARGURA-1:0] rd_val;
  logic [NUM_LEITURA-1:0]         rd_oc;
  logic [AW-1:0]                  a;
  logic                           byp;

  // Combinational read ports with optional same-cycle forwarding
  always_comb begin
    rd_val = '0;
    rd_oc  = '0;
    a      = '0;
    byp    = 1'b0;
    for (int k = 0; k < NUM_LEITURA; k++) begin
      a   = bus.endereco_leitura[k*AW +: AW];
      byp = (BYPASS != 0) && wr_ok && (a == wa);
      if (valido(a)) begin
        rd_val[k*LARGURA +: LARGURA] =
          byp ? bus.dado_escrita : mem[a];
        rd_oc[k] = pend[a] &&
          !(byp && !(rs_ok && (ra == a)));
      end
    end
  end

  assign bus.valor_leitura = rd_val;
  assign bus.ocupado       = rd_oc;
  assign bus.num_pendentes = cnt;
endmodule
